dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/load_extend.sv | 38 +++
 rtl/dmem_responder.sv | 189 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and func3 encodings for the data-memory
//               responder and its load-extension helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // RISC-V load/store func3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Number of bytes a store touches; 0 for encodings that are not stores
    function automatic logic [2:0] store_bytes(input logic [2:0] f3);
        case (f3)
            F3_B:    store_bytes = 3'd1;
            F3_H:    store_bytes = 3'd2;
            F3_W:    store_bytes = 3'd4;
            default: store_bytes = 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Selects the addressed byte/halfword from a little-endian
//               32-bit word and sign- or zero-extends it to DATA_W.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       word,
    input  logic [1:0]        addr,
    input  logic [2:0]        func3,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select by low address bits, then extend according to func3
    always_comb begin
        w_byte = word[{addr, 3'b000} +: 8];
        w_half = addr[1] ? word[31:16] : word[15:0];
        result = '0;
        case (func3)
            F3_B:    result = DATA_W'($signed(w_byte));
            F3_H:    result = DATA_W'($signed(w_half));
            F3_W:    result = DATA_W'(word);
            F3_BU:   result = DATA_W'(w_byte);
            F3_HU:   result = DATA_W'(w_half);
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Byte-addressed data memory behind a valid/ready request and
//               a one-cycle response strobe, with a programmable number of
//               wait cycles. Handles RISC-V byte/half/word loads and stores.
//               DATA_W must be at least 32.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [2:0]            func3,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  err
);

    localparam int         c_DEPTH    = 1 << DM_ADDRESS;
    localparam logic [3:0] c_CNT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_cnt;
    logic                  w_accept;

    // Request captured on accept
    logic                  r_rd;
    logic                  r_wr;
    logic [DM_ADDRESS-1:0] r_addr;
    logic [2:0]            r_func3;
    logic [DATA_W-1:0]     r_wdata;

    // Request actually being committed on the edge that enters RESP
    logic                  w_commit;
    logic                  w_from_latch;
    logic                  w_c_rd;
    logic                  w_c_wr;
    logic [DM_ADDRESS-1:0] w_c_addr;
    logic [2:0]            w_c_func3;
    logic [DATA_W-1:0]     w_c_wdata;
    logic                  w_err;
    logic                  w_mem_we;
    logic [2:0]            w_nbytes;
    logic [DM_ADDRESS-1:0] w_base;
    logic [31:0]           w_word;
    logic [DATA_W-1:0]     w_load;

    logic [DATA_W-1:0]     r_rd_data;
    logic                  r_err;
    logic [7:0]            r_mem [c_DEPTH];

    assign req_ready = (r_state != S_WAIT);
    assign rsp_valid = (r_state == S_RESP);
    assign rd_data   = r_rd_data;
    assign err       = r_err;
    assign w_accept  = req_valid && req_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic; RESP accepts a new request just like IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (w_accept) w_next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                else          w_next_state = S_IDLE;
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) w_next_state = S_RESP;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Wait counter: loaded on accept, counts down to zero while in WAIT
    always_ff @(posedge clk) begin
        if (!reset)                                 r_cnt <= 4'd0;
        else if (w_accept)                          r_cnt <= c_CNT_LOAD;
        else if (r_state == S_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end

    // Latch the request fields on accept
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_func3 <= 3'd0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_rd    <= MemRead;
            r_wr    <= MemWrite;
            r_addr  <= addr;
            r_func3 <= func3;
            r_wdata <= wr_data;
        end
    end

    // With zero wait cycles the commit happens on the accept edge itself,
    // so the live request inputs are used instead of the latched copy.
    assign w_commit     = (w_next_state == S_RESP);
    assign w_from_latch = (r_state == S_WAIT);
    assign w_c_rd       = w_from_latch ? r_rd    : MemRead;
    assign w_c_wr       = w_from_latch ? r_wr    : MemWrite;
    assign w_c_addr     = w_from_latch ? r_addr  : addr;
    assign w_c_func3    = w_from_latch ? r_func3 : func3;
    assign w_c_wdata    = w_from_latch ? r_wdata : wr_data;

    // Error decode: bad op combination, unknown func3, or misalignment
    always_comb begin
        w_err = 1'b0;
        if (w_c_rd == w_c_wr) begin
            w_err = 1'b1;
        end else if (w_c_rd) begin
            case (w_c_func3)
                F3_B, F3_BU: w_err = 1'b0;
                F3_H, F3_HU: w_err = w_c_addr[0];
                F3_W:        w_err = (w_c_addr[1:0] != 2'b00);
                default:     w_err = 1'b1;
            endcase
        end else begin
            case (w_c_func3)
                F3_B:    w_err = 1'b0;
                F3_H:    w_err = w_c_addr[0];
                F3_W:    w_err = (w_c_addr[1:0] != 2'b00);
                default: w_err = 1'b1;
            endcase
        end
    end

    assign w_nbytes = store_bytes(w_c_func3);
    assign w_mem_we = reset && w_commit && w_c_wr && !w_err;

    // Little-endian word containing the addressed location
    assign w_base = {w_c_addr[DM_ADDRESS-1:2], 2'b00};
    assign w_word = {r_mem[w_base + DM_ADDRESS'(3)], r_mem[w_base + DM_ADDRESS'(2)],
                     r_mem[w_base + DM_ADDRESS'(1)], r_mem[w_base]};

    load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .word   (w_word),
        .addr   (w_c_addr[1:0]),
        .func3  (w_c_func3),
        .result (w_load)
    );

    // Byte-lane store; array is deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (k < int'(w_nbytes)) r_mem[w_c_addr + DM_ADDRESS'(k)] <= w_c_wdata[8*k +: 8];
            end
        end
    end

    // Response data/error registers: populated only on the edge entering RESP
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_data <= '0;
            r_err     <= 1'b0;
        end else if (w_commit) begin
            r_rd_data <= (w_c_rd && !w_err) ? w_load : '0;
            r_err     <= w_err;
        end else begin
            r_rd_data <= '0;
            r_err     <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder, with one
//               instance at WAIT_CYCLES=1 and one at WAIT_CYCLES=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        req_valid = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic [8:0]  addr = '0;
    logic [2:0]  func3 = '0;
    logic [31:0] wr_data = '0;
    logic        req_ready, rsp_valid, err;
    logic [31:0] rd_data;

    logic        z_req_valid = 1'b0, z_MemRead = 1'b0, z_MemWrite = 1'b0;
    logic [8:0]  z_addr = '0;
    logic [2:0]  z_func3 = '0;
    logic [31:0] z_wr_data = '0;
    logic        z_req_ready, z_rsp_valid, z_err;
    logic [31:0] z_rd_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .func3(func3),
        .wr_data(wr_data), .rsp_valid(rsp_valid), .rd_data(rd_data), .err(err)
    );

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .MemRead(z_MemRead), .MemWrite(z_MemWrite), .addr(z_addr), .func3(z_func3),
        .wr_data(z_wr_data), .rsp_valid(z_rsp_valid), .rd_data(z_rd_data), .err(z_err)
    );

    // Single request on u_dut from IDLE; lat counts the accept cycle as 0
    task automatic do_req(input logic rd, input logic wr, input logic [8:0] a,
                          input logic [2:0] f, input logic [31:0] wd,
                          output logic [31:0] d, output logic e, output int lat,
                          output logic after_v);
        @(negedge clk);
        MemRead = rd; MemWrite = wr; addr = a; func3 = f; wr_data = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        lat = 99; d = 32'hx; e = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                lat = k + 1; d = rd_data; e = err;
                break;
            end
        end
        @(posedge clk); #1;
        after_v = rsp_valid;
    endtask

    task automatic test_reset();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else pass_cnt++;
        total_cnt++; if (rd_data !== 32'h0) $display("FAIL reset_rd_data got %h exp 0", rd_data); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready); else pass_cnt++;
        total_cnt++; if (z_rsp_valid !== 1'b0 || z_req_ready !== 1'b1) $display("FAIL reset_w0 got v=%b r=%b exp v=0 r=1", z_rsp_valid, z_req_ready); else pass_cnt++;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_store_load();
        logic [31:0] d; logic e, av; int lat;
        do_req(1'b0, 1'b1, 9'h010, 3'b010, 32'hDEADBEEF, d, e, lat, av);
        total_cnt++; if (lat !== 2) $display("FAIL sw_latency got %0d exp 2", lat); else pass_cnt++;
        total_cnt++; if (e !== 1'b0 || d !== 32'h0) $display("FAIL sw_resp got err=%b d=%h exp err=0 d=0", e, d); else pass_cnt++;
        total_cnt++; if (av !== 1'b0) $display("FAIL sw_one_cycle got %b exp 0", av); else pass_cnt++;
        do_req(1'b1, 1'b0, 9'h010, 3'b010, 32'h0, d, e, lat, av);
        total_cnt++; if (lat !== 2) $display("FAIL lw_latency got %0d exp 2", lat); else pass_cnt++;
        total_cnt++; if (d !== 32'hDEADBEEF || e !== 1'b0) $display("FAIL lw_data got %h err=%b exp deadbeef err=0", d, e); else pass_cnt++;
        total_cnt++; if (av !== 1'b0) $display("FAIL lw_one_cycle got %b exp 0", av); else pass_cnt++;
    endtask

    task automatic test_subword_loads();
        logic [31:0] d; logic e, av; int lat;
        logic [8:0]  va [7] = '{9'h013, 9'h013, 9'h012, 9'h012, 9'h010, 9'h010, 9'h011};
        logic [2:0]  vf [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b100};
        logic [31:0] vx [7] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD,
                                32'hFFFFFFEF, 32'hFFFFBEEF, 32'h000000BE};
        for (int i = 0; i < 7; i++) begin
            do_req(1'b1, 1'b0, va[i], vf[i], 32'h0, d, e, lat, av);
            total_cnt++;
            if (d !== vx[i] || e !== 1'b0 || lat !== 2)
                $display("FAIL subword_load%0d got d=%h err=%b lat=%0d exp d=%h err=0 lat=2", i, d, e, lat, vx[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_errors_and_merge();
        logic [31:0] d; logic e, av; int lat;
        do_req(1'b0, 1'b1, 9'h011, 3'b001, 32'h0000AAAA, d, e, lat, av);
        total_cnt++; if (e !== 1'b1 || d !== 32'h0) $display("FAIL sh_misaligned got err=%b d=%h exp err=1 d=0", e, d); else pass_cnt++;
        do_req(1'b1, 1'b0, 9'h010, 3'b010, 32'h0, d, e, lat, av);
        total_cnt++; if (d !== 32'hDEADBEEF) $display("FAIL after_bad_sh got %h exp deadbeef", d); else pass_cnt++;
        do_req(1'b1, 1'b0, 9'h012, 3'b010, 32'h0, d, e, lat, av);
        total_cnt++; if (e !== 1'b1 || d !== 32'h0) $display("FAIL lw_misaligned got err=%b d=%h exp err=1 d=0", e, d); else pass_cnt++;
        do_req(1'b1, 1'b0, 9'h013, 3'b101, 32'h0, d, e, lat, av);
        total_cnt++; if (e !== 1'b1 || d !== 32'h0) $display("FAIL lhu_misaligned got err=%b d=%h exp err=1 d=0", e, d); else pass_cnt++;
        do_req(1'b0, 1'b1, 9'h010, 3'b100, 32'h55555555, d, e, lat, av);
        total_cnt++; if (e !== 1'b1) $display("FAIL store_bad_func3 got err=%b exp 1", e); else pass_cnt++;
        do_req(1'b0, 1'b1, 9'h010, 3'b000, 32'h12345677, d, e, lat, av);
        total_cnt++; if (e !== 1'b0) $display("FAIL sb_err got %b exp 0", e); else pass_cnt++;
        do_req(1'b1, 1'b0, 9'h010, 3'b010, 32'h0, d, e, lat, av);
        total_cnt++; if (d !== 32'hDEADBE77) $display("FAIL sb_merge got %h exp deadbe77", d); else pass_cnt++;
        do_req(1'b0, 1'b1, 9'h014, 3'b010, 32'h11223344, d, e, lat, av);
        do_req(1'b0, 1'b1, 9'h016, 3'b001, 32'hABCD5678, d, e, lat, av);
        do_req(1'b1, 1'b0, 9'h014, 3'b010, 32'h0, d, e, lat, av);
        total_cnt++; if (d !== 32'h56783344) $display("FAIL sh_merge got %h exp 56783344", d); else pass_cnt++;
    endtask

    task automatic test_reset_inflight();
        logic [31:0] d; logic e, av; int lat;
        logic saw;
        do_req(1'b0, 1'b1, 9'h020, 3'b010, 32'h00000000, d, e, lat, av);
        @(negedge clk);
        MemWrite = 1'b1; addr = 9'h020; func3 = 3'b010; wr_data = 32'hCAFEF00D; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; MemWrite = 1'b0; reset = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) saw = 1'b1;
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        if (rsp_valid) saw = 1'b1;
        total_cnt++; if (saw !== 1'b0) $display("FAIL inflight_no_rsp got %b exp 0", saw); else pass_cnt++;
        do_req(1'b1, 1'b0, 9'h020, 3'b010, 32'h0, d, e, lat, av);
        total_cnt++; if (d !== 32'h0 || e !== 1'b0) $display("FAIL inflight_discard got %h err=%b exp 0 err=0", d, e); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic        ev [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [8:0]  ra [3] = '{9'h010, 9'h010, 9'h010};
        logic [2:0]  rf [3] = '{3'b010, 3'b011, 3'b010};
        logic        rr [3] = '{1'b1, 1'b1, 1'b1};
        logic        rw [3] = '{1'b0, 1'b0, 1'b1};
        logic        sv [7]; logic se [7]; logic [31:0] sd [7];
        logic        rdy;
        int          acc = 0;
        @(negedge clk);
        MemRead = rr[0]; MemWrite = rw[0]; addr = ra[0]; func3 = rf[0]; req_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            rdy = req_ready;
            @(posedge clk); #1;
            sv[k] = rsp_valid; se[k] = err; sd[k] = rd_data;
            if (rdy && req_valid) acc++;
            @(negedge clk);
            if (rdy && req_valid) begin
                if (acc < 3) begin
                    MemRead = rr[acc]; MemWrite = rw[acc]; addr = ra[acc]; func3 = rf[acc];
                end else begin
                    req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
                end
            end
        end
        for (int k = 0; k < 7; k++) begin
            total_cnt++;
            if (sv[k] !== ev[k]) $display("FAIL b2b_rsp_valid%0d got %b exp %b", k, sv[k], ev[k]); else pass_cnt++;
        end
        total_cnt++; if (acc !== 3) $display("FAIL b2b_accepts got %0d exp 3", acc); else pass_cnt++;
        total_cnt++;
        if (se[1] !== 1'b0 || se[3] !== 1'b1 || se[5] !== 1'b1)
            $display("FAIL b2b_err_seq got %b%b%b exp 011", se[1], se[3], se[5]);
        else pass_cnt++;
        total_cnt++;
        if (sd[1] !== 32'hDEADBE77 || sd[3] !== 32'h0 || sd[5] !== 32'h0)
            $display("FAIL b2b_data got %h %h %h exp deadbe77 0 0", sd[1], sd[3], sd[5]);
        else pass_cnt++;
    endtask

    task automatic test_zero_wait();
        logic        zr [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic        zw [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [8:0]  za [4] = '{9'h040, 9'h040, 9'h043, 9'h041};
        logic [2:0]  zf [4] = '{3'b010, 3'b010, 3'b000, 3'b010};
        logic        xv [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] xd [5] = '{32'h0, 32'h81020304, 32'hFFFFFF81, 32'h0, 32'h0};
        logic        xe [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        z_MemRead = zr[0]; z_MemWrite = zw[0]; z_addr = za[0]; z_func3 = zf[0];
        z_wr_data = 32'h81020304; z_req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (z_rsp_valid !== xv[k] || z_rd_data !== xd[k] || z_err !== xe[k])
                $display("FAIL w0_cycle%0d got v=%b d=%h e=%b exp v=%b d=%h e=%b",
                         k, z_rsp_valid, z_rd_data, z_err, xv[k], xd[k], xe[k]);
            else pass_cnt++;
            @(negedge clk);
            if (k < 3) begin
                z_MemRead = zr[k+1]; z_MemWrite = zw[k+1]; z_addr = za[k+1]; z_func3 = zf[k+1];
            end else begin
                z_req_valid = 1'b0; z_MemRead = 1'b0; z_MemWrite = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_load();
        test_subword_loads();
        test_errors_and_merge();
        test_reset_inflight();
        test_back_to_back();
        test_zero_wait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
